// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   hz_state_e      : hazard controller sequencing state (RUN, MD_BUSY)
//   REG_ZERO        : architectural $zero register index
//   MD_LATENCY_DEF  : default cycles a mul/div occupies EX
//   STALL_MAX       : saturation value of the stall cycle counter
package mips_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_e;

   localparam logic [4:0]  REG_ZERO       = 5'd0;
   localparam int          MD_LATENCY_DEF = 4;
   localparam logic [15:0] STALL_MAX      = 16'hFFFF;

endpackage

// File: rtl/hazard_ctl_if.sv
// Hazard controller bundle between the pipeline datapath and hazard_ctl.
//   master : pipeline side, drives ID/EX/MEM hazard sources, receives
//            register enables, flush/bubble controls and status
//   slave  : hazard_ctl side
// Signals:
//   id_rs, id_rt, id_uses_rt      ID-stage source operands
//   ex_memread, ex_rt, ex_md      EX-stage load / mul-div information
//   branch_taken                  MEM-stage taken branch
//   pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
//   exmem_bubble                  pipeline register controls
//   md_done                       mul/div release pulse
//   stall_count                   saturating stall cycle count
interface hazard_ctl_if;

   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_memread;
   logic [4:0]  ex_rt;
   logic        ex_md;
   logic        branch_taken;

   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_write;
   logic        idex_bubble;
   logic        exmem_bubble;
   logic        md_done;
   logic [15:0] stall_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_md, branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
             exmem_bubble, md_done, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_md, branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
             exmem_bubble, md_done, stall_count
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare, shareable with the forwarding unit.
//   ex_memread, ex_rt : load in EX and its destination register
//   id_rs, id_rt      : source fields of the instruction in ID
//   id_uses_rt        : ID instruction actually reads rt
//   hazard            : ID needs the load result before it exists
module hazard_detect
   import mips_pkg::*;
(
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       hazard
);

   // A load into $zero never creates a dependency.
   assign hazard = ex_memread && (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Inserts a one-cycle bubble on load-use hazards, freezes PC/IF/ID/ID-EX
// while a multi-cycle mul/div holds EX, and flushes wrong-path work when
// a branch resolves taken in MEM. All controls are Mealy outputs.
//   clk, rst : clock and synchronous active-high reset
//   hif      : hazard_ctl_if.slave (hazard sources in, register controls,
//              md_done pulse and stall_count out)
module hazard_ctl
   import mips_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEF
) (
   input  logic        clk,
   input  logic        rst,
   hazard_ctl_if.slave hif
);

   localparam bit         MD_MULTI  = (MD_LATENCY > 1);
   // Start cycle is the first freeze cycle, so the counter covers the rest.
   localparam logic [4:0] MD_RELOAD = MD_MULTI ? 5'(MD_LATENCY - 2) : 5'd0;

   hz_state_e   state;
   logic [4:0]  md_cnt;
   logic [15:0] stall_cnt;
   logic        load_use;
   logic        md_start;

   hazard_detect u_detect (
      .ex_memread (hif.ex_memread),
      .ex_rt      (hif.ex_rt),
      .id_rs      (hif.id_rs),
      .id_rt      (hif.id_rt),
      .id_uses_rt (hif.id_uses_rt),
      .hazard     (load_use)
   );

   assign md_start        = (state == RUN) && !hif.branch_taken && hif.ex_md && MD_MULTI;
   assign hif.stall_count = stall_cnt;

   always_comb begin
      hif.pc_write     = 1'b1;
      hif.ifid_write   = 1'b1;
      hif.ifid_flush   = 1'b0;
      hif.idex_write   = 1'b1;
      hif.idex_bubble  = 1'b0;
      hif.exmem_bubble = 1'b0;
      hif.md_done      = 1'b0;
      if (rst) begin
         // Hold PC and drain every stage to NOPs while in reset.
         hif.pc_write     = 1'b0;
         hif.ifid_flush   = 1'b1;
         hif.idex_bubble  = 1'b1;
         hif.exmem_bubble = 1'b1;
      end else if (state == MD_BUSY) begin
         if (md_cnt != 5'd0) begin
            hif.pc_write     = 1'b0;
            hif.ifid_write   = 1'b0;
            hif.idex_write   = 1'b0;
            hif.exmem_bubble = 1'b1;
         end else begin
            hif.md_done = 1'b1;
         end
      end else if (hif.branch_taken) begin
         // Squash everything younger than the branch, including a mul/div in EX.
         hif.ifid_flush   = 1'b1;
         hif.idex_bubble  = 1'b1;
         hif.exmem_bubble = 1'b1;
      end else if (md_start) begin
         hif.pc_write     = 1'b0;
         hif.ifid_write   = 1'b0;
         hif.idex_write   = 1'b0;
         hif.exmem_bubble = 1'b1;
      end else begin
         // Single-cycle mul/div completes in place.
         if (hif.ex_md) begin
            hif.md_done = 1'b1;
         end
         if (load_use) begin
            hif.pc_write    = 1'b0;
            hif.ifid_write  = 1'b0;
            hif.idex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         md_cnt    <= 5'd0;
         stall_cnt <= 16'd0;
      end else begin
         if (!hif.pc_write && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         case (state)
            RUN: begin
               if (md_start) begin
                  state  <= MD_BUSY;
                  md_cnt <= MD_RELOAD;
               end
            end
            MD_BUSY: begin
               if (md_cnt == 5'd0) begin
                  state <= RUN;
               end else begin
                  md_cnt <= md_cnt - 5'd1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed and random stimulus, a
// cycle-level reference model and a scoreboard queue checked by a monitor.
module tb_hazard_ctl;

   localparam int LAT = 4;

   // Control vector order: pc_write, ifid_write, ifid_flush, idex_write,
   // idex_bubble, exmem_bubble, md_done
   localparam logic [6:0] C_DEF = 7'b1101000;
   localparam logic [6:0] C_RST = 7'b0111110;
   localparam logic [6:0] C_FLU = 7'b1111110;
   localparam logic [6:0] C_FRZ = 7'b0000010;
   localparam logic [6:0] C_REL = 7'b1101001;
   localparam logic [6:0] C_LU  = 7'b0001100;

   typedef struct {
      logic [22:0] exp;
      string       tag;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   hazard_ctl_if hif ();

   sb_t q[$];
   int  checks   = 0;
   int  failures = 0;
   int  md_left  = 0;
   int  stalls   = 0;
   int  cyc      = 0;

   hazard_ctl #(.MD_LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .hif (hif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: one call per clock cycle.
   task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] ert,
                       input logic md, input logic br, input string tag);
      sb_t        e;
      logic [6:0] ctl;
      bit         hz;
      @(posedge clk);
      #1;
      rst              = r;
      hif.id_rs        = rs;
      hif.id_rt        = rt;
      hif.id_uses_rt   = urt;
      hif.ex_memread   = mr;
      hif.ex_rt        = ert;
      hif.ex_md        = md;
      hif.branch_taken = br;
      hz  = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
      ctl = C_DEF;
      if (r) begin
         ctl     = C_RST;
         md_left = 0;
      end else if (md_left > 0) begin
         ctl     = (md_left == 1) ? C_REL : C_FRZ;
         md_left = md_left - 1;
      end else if (br) begin
         ctl = C_FLU;
      end else if (md) begin
         ctl     = C_FRZ;
         md_left = LAT - 1;
      end else if (hz) begin
         ctl = C_LU;
      end
      e.exp = {ctl, 16'(stalls)};
      e.tag = tag;
      q.push_back(e);
      if (r) stalls = 0;
      else if (!ctl[6] && stalls < 65535) stalls = stalls + 1;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, tag);
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
   initial begin
      sb_t         e;
      logic [22:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_write,
                   hif.idex_bubble, hif.exmem_bubble, hif.md_done, hif.stall_count};
            checks = checks + 1;
            if (act !== e.exp) begin
               failures = failures + 1;
               $display("FAIL %s cycle=%0d got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                        e.tag, cyc, act[22:16], act[15:0], e.exp[22:16], e.exp[15:0]);
            end
         end
      end
   end

   initial begin
      logic [4:0] rs, rt, ert;
      logic       urt, mr, md, br, r;
      hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_uses_rt = 1'b0;
      hif.ex_memread = 1'b0; hif.ex_rt = 5'd0; hif.ex_md = 1'b0;
      hif.branch_taken = 1'b0;

      step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, "reset");
      step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, "reset");
      idle(2, "idle");

      // Load-use: lw $5 in EX, ID reads $5
      step(0, 5'd5, 5'd3, 1, 1, 5'd5, 0, 0, "load_use");
      step(0, 5'd5, 5'd3, 1, 0, 5'd0, 0, 0, "load_use_after");
      // Load-use through rt
      step(0, 5'd9, 5'd6, 1, 1, 5'd6, 0, 0, "load_use_rt");
      idle(1, "idle");

      // $zero and unused rt never stall
      step(0, 5'd0, 5'd4, 1, 1, 5'd0, 0, 0, "reg_zero");
      step(0, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, "rt_unused");

      // Mul/div: 3 freeze cycles then release
      step(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, "md_start");
      for (int i = 0; i < LAT - 1; i++) step(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, "md_busy");
      idle(2, "md_after");

      // Branch beats mul/div start and load-use
      step(0, 5'd5, 5'd2, 1, 1, 5'd5, 1, 1, "branch_prio");
      idle(2, "branch_after");

      // Reset on the 2nd MD_BUSY cycle abandons the op
      step(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, "md_start2");
      step(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, "md_busy2");
      step(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, "reset_mid_md");
      idle(3, "after_reset");

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         rs  = 5'($urandom_range(0, 3));
         rt  = 5'($urandom_range(0, 3));
         ert = 5'($urandom_range(0, 3));
         urt = 1'($urandom_range(0, 1));
         mr  = 1'($urandom_range(0, 1));
         md  = ($urandom_range(0, 7) == 0);
         br  = (md_left == 0) && ($urandom_range(0, 7) == 0);
         r   = ($urandom_range(0, 63) == 0);
         step(r, rs, rt, urt, mr, ert, md, br, "random");
      end

      // Saturation: continuous load-use stalls
      step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, "reset");
      for (int i = 0; i < 70000; i++) step(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, "saturate");
      idle(2, "sat_after");

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
